// File: rtl/ara_req_arbiter.sv
// ara_req_arbiter
// ---------------------------------------------------------------------------
// Shares the single Ara sequencer request port between NrReq dispatchers.
// A requester is picked round-robin while the arbiter is idle. That requester
// then owns the port until its request is accepted, so a sequencer that holds
// ready low (waiting on address translation or a scalar response) cannot have
// the grant taken away. Responses from the sequencer go back to the current
// owner only.
//
// Handshake semantics (all ports): a transfer happens in a cycle where valid
// and ready are both high. The arbiter never looks at ready to decide valid.
// A granted owner that drops valid before its transfer completes is a
// protocol error: the grant is released and err_o is set.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i[NrReq]        dispatcher requests
//   req_valid_i[NrReq]  request valid per dispatcher
//   req_ready_o[NrReq]  request accepted (only the owner's bit can be high)
//   resp_o[NrReq]       sequencer response routed to the owner
//   resp_valid_o[NrReq] response valid per dispatcher
//   ara_req_o           request towards the sequencer
//   ara_req_valid_o     request valid towards the sequencer
//   ara_req_ready_i     sequencer accepts the request
//   ara_resp_i          sequencer response
//   ara_resp_valid_i    sequencer response valid
//   owner_o             index of the current (or most recent) grant
//   busy_o              high while a grant is held (FSM state GRANTED)
//   err_o               sticky protocol error
//   timeout_o           sticky watchdog flag
//
// Build option
//   ARA_REQ_ARB_TIMEOUT_EN  when defined, a watchdog counts consecutive
//                           granted cycles and raises timeout_o once the
//                           count reaches TimeoutCycles. The grant is kept.
//                           When undefined, timeout_o is tied low.
// ---------------------------------------------------------------------------

package ara_req_arbiter_pkg;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] scalar_op;
        logic [4:0]  vd;
    } ara_req_t;

    typedef struct packed {
        logic [31:0] resp;
        logic        error;
    } ara_resp_t;

endpackage

module ara_req_arbiter
    import ara_req_arbiter_pkg::*;
#(
    parameter int unsigned NrReq         = 2,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdxW         = (NrReq > 2) ? $clog2(NrReq) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  ara_req_t  [NrReq-1:0] req_i,
    input  logic      [NrReq-1:0] req_valid_i,
    output logic      [NrReq-1:0] req_ready_o,

    output ara_resp_t [NrReq-1:0] resp_o,
    output logic      [NrReq-1:0] resp_valid_o,

    output ara_req_t              ara_req_o,
    output logic                  ara_req_valid_o,
    input  logic                  ara_req_ready_i,
    input  ara_resp_t             ara_resp_i,
    input  logic                  ara_resp_valid_i,

    output logic      [IdxW-1:0]  owner_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic                  timeout_o
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] rr_q, rr_d;
    logic            err_q, err_d;

    logic [IdxW-1:0] winner;
    logic            found;
    logic            owner_valid;
    logic            handshake;

    assign owner_valid = req_valid_i[owner_q];

    // Round-robin pick: first valid requester at or above rr_q, wrapping.
    // rr_q and the offset are both below NrReq, so one subtraction is enough
    // to fold the sum back into range.
    always_comb begin
        logic [IdxW:0] cand;
        winner = rr_q;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NrReq; i++) begin
            cand = {1'b0, rr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NrReq)) begin
                cand = cand - (IdxW+1)'(NrReq);
            end
            if (!found && req_valid_i[cand[IdxW-1:0]]) begin
                winner = cand[IdxW-1:0];
                found  = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        err_d     = err_q;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                // Nobody owns the port, so a response here has nowhere to go.
                if (ara_resp_valid_i) begin
                    err_d = 1'b1;
                end
                if (found) begin
                    owner_d = winner;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                handshake = owner_valid && ara_req_ready_i;
                if (handshake) begin
                    state_d = IDLE;
                    rr_d    = (owner_q == IdxW'(NrReq - 1)) ? '0 : owner_q + IdxW'(1);
                end else if (!owner_valid) begin
                    // Owner withdrew its request: release without advancing
                    // the round-robin pointer.
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    // Datapath: everything is a pure function of the state and the inputs of
    // the current cycle, so a response arriving together with the handshake
    // still reaches the owner before the grant is dropped.
    always_comb begin
        ara_req_o       = '0;
        ara_req_valid_o = 1'b0;
        req_ready_o     = '0;
        resp_o          = '0;
        resp_valid_o    = '0;
        if (state_q == GRANTED) begin
            ara_req_o            = req_i[owner_q];
            ara_req_valid_o      = owner_valid;
            req_ready_o[owner_q] = ara_req_ready_i;
            if (ara_resp_valid_i) begin
                resp_valid_o[owner_q] = 1'b1;
                resp_o[owner_q]       = ara_resp_i;
            end
        end
    end

    assign owner_o = owner_q;
    assign busy_o  = (state_q == GRANTED);
    assign err_o   = err_q;

`ifdef ARA_REQ_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            to_q, to_d;

    // Counts granted cycles that stay granted; saturates at the limit so the
    // flag cannot be missed by wrap-around. Any return to IDLE clears it.
    always_comb begin
        cnt_d = '0;
        to_d  = to_q;
        if (state_q == GRANTED && state_d == GRANTED) begin
            cnt_d = cnt_q;
            if (cnt_q != CntW'(TimeoutCycles)) begin
                cnt_d = cnt_q + CntW'(1);
            end
            if (cnt_d == CntW'(TimeoutCycles)) begin
                to_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    // Watchdog not built; the limit parameter has no effect.
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TimeoutCycles);
    assign timeout_o             = 1'b0;
`endif

endmodule

// File: tb/tb_ara_req_arbiter.sv
// Testbench for ara_req_arbiter (three requesters, TimeoutCycles = 16).
// A table of per-cycle vectors covers round-robin order, wrap-around and
// single-requester cases; hand-written sequences cover long stalls, response
// routing, protocol errors and reset in the middle of a grant. Responses are
// checked through an expected queue filled when the response is driven.

module tb_ara_req_arbiter;
    import ara_req_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int TO = 16;
    localparam int RW = $bits(ara_resp_t);
    localparam int W  = N + RW;

`ifdef ARA_REQ_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT
    ara_req_t  [N-1:0] req;
    logic      [N-1:0] req_valid;
    logic      [N-1:0] req_ready;
    ara_resp_t [N-1:0] resp;
    logic      [N-1:0] resp_valid;
    ara_req_t          ara_req;
    logic              ara_req_valid;
    logic              ara_req_ready;
    ara_resp_t         ara_resp;
    logic              ara_resp_valid;
    logic [IW-1:0]     owner;
    logic              busy;
    logic              err;
    logic              timeout;

    ara_req_arbiter #(
        .NrReq        (N),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .resp_o          (resp),
        .resp_valid_o    (resp_valid),
        .ara_req_o       (ara_req),
        .ara_req_valid_o (ara_req_valid),
        .ara_req_ready_i (ara_req_ready),
        .ara_resp_i      (ara_resp),
        .ara_resp_valid_i(ara_resp_valid),
        .owner_o         (owner),
        .busy_o          (busy),
        .err_o           (err),
        .timeout_o       (timeout)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_vec  = 0;
    int n_miss = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string what, input int tag,
                       input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (step %0d): got %h, expected %h", what, tag, act, exp);
        end
    endtask

    // Pops at most one expected response per cycle; an empty queue means no
    // lane may show a response.
    task automatic check_resp(input int tag);
        logic [W-1:0] e;
        logic [N-1:0] exp_vld;
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        exp_vld = e[W-1:RW];
        chk("resp_valid", tag, 64'(resp_valid), 64'(exp_vld));
        for (int i = 0; i < N; i++) begin
            chk("resp_lane", tag, 64'(resp[i]), exp_vld[i] ? 64'(e[RW-1:0]) : 64'd0);
        end
    endtask

    // ---------------------------------------------------------------- driver
    // Called just after a falling edge: drives one cycle of inputs, records
    // any expected response, checks outputs, then moves to the next falling
    // edge.
    task automatic step(input int tag, input logic [N-1:0] v, input logic rdy,
                        input logic rv, input logic rerr,
                        input logic eb, input logic [IW-1:0] eo, input logic earv,
                        input logic [N-1:0] erdy, input logic eerr, input logic eto);
        logic [N-1:0] onehot;
        req_valid          = v;
        ara_req_ready      = rdy;
        ara_resp_valid     = rv;
        ara_resp.resp      = $urandom;
        ara_resp.error     = rerr;
        if (rv && eb) begin
            onehot = N'(1) << eo;
            exp_q.push_back({onehot, ara_resp});
        end
        #1;
        chk("busy",          tag, 64'(busy),          64'(eb));
        chk("owner",         tag, 64'(owner),         64'(eo));
        chk("ara_req_valid", tag, 64'(ara_req_valid), 64'(earv));
        chk("req_ready",     tag, 64'(req_ready),     64'(erdy));
        chk("ara_req",       tag, 64'(ara_req),       eb ? 64'(req[eo]) : 64'd0);
        chk("err",           tag, 64'(err),           64'(eerr));
        chk("timeout",       tag, 64'(timeout),       64'(eto));
        check_resp(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid      = '0;
        ara_req_ready  = 1'b0;
        ara_resp_valid = 1'b0;
        rst            = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic [N-1:0]  v;
        logic          rdy;
        logic          rv;
        logic          eb;
        logic [IW-1:0] eo;
        logic          earv;
        logic [N-1:0]  erdy;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // v, rdy, rv | busy, owner, ara_req_valid, req_ready
        tbl[0]  = '{3'b011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
        tbl[1]  = '{3'b011, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 3'b001};
        tbl[2]  = '{3'b011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
        tbl[3]  = '{3'b011, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 3'b010};
        tbl[4]  = '{3'b011, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000};
        tbl[5]  = '{3'b011, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 3'b001};
        tbl[6]  = '{3'b011, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
        tbl[7]  = '{3'b011, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 3'b010};
        tbl[8]  = '{3'b111, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000};
        tbl[9]  = '{3'b111, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 3'b000};
        tbl[10] = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 3'b100};
        tbl[11] = '{3'b110, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 3'b000};
        tbl[12] = '{3'b110, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 3'b010};
        tbl[13] = '{3'b010, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000};
        tbl[14] = '{3'b010, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 3'b010};
        tbl[15] = '{3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000};
        tbl[16] = '{3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000};

        for (int i = 0; i < N; i++) begin
            req[i].op        = 8'h10 + 8'(i);
            req[i].scalar_op = $urandom;
            req[i].vd        = 5'(i + 3);
        end
        ara_resp       = '0;
        req_valid      = '0;
        ara_req_ready  = 1'b0;
        ara_resp_valid = 1'b0;
        rst            = 1'b1;

        @(negedge clk);
        // Reset held: all outputs idle even with busy-looking inputs.
        step(0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        rst = 1'b0;

        // Round-robin order, wrap-around, single requester.
        for (int k = 0; k < 17; k++) begin
            step(10 + k, tbl[k].v, tbl[k].rdy, tbl[k].rv, 1'b0,
                 tbl[k].eb, tbl[k].eo, tbl[k].earv, tbl[k].erdy, 1'b0, 1'b0);
        end

        // Long stall on owner 0 while requester 1 waits; watchdog if built.
        do_reset();
        step(100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++) begin
            step(101 + j, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 3'b000,
                 1'b0, TO_EN && (j >= TO));
        end
        // Accept plus error response in the same cycle.
        step(130, 3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001, 1'b0, TO_EN);
        step(131, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, TO_EN);
        step(132, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 3'b000, 1'b0, TO_EN);

        // Owner 1 withdraws its request: error, idle, pointer stays at 1.
        step(140, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3'b000, 1'b0, TO_EN);
        step(141, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000, 1'b1, TO_EN);
        step(142, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 3'b010, 1'b1, TO_EN);
        step(143, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'b000, 1'b1, TO_EN);

        // Response while idle: dropped, sticky error until reset.
        do_reset();
        step(150, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        step(151, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step(152 + j, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b1, 1'b0);
        end

        // Reset pulse while owner 1 holds the grant.
        do_reset();
        step(160, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        step(161, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 1'b0, 1'b0);
        step(162, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        step(163, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 3'b000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_ara_req_valid", 170, 64'(ara_req_valid), 64'd0);
        chk("rst_busy",          170, 64'(busy),          64'd0);
        chk("rst_req_ready",     170, 64'(req_ready),     64'd0);
        chk("rst_owner",         170, 64'(owner),         64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(171, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0);
        step(172, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 1'b0, 1'b0);

        chk("sb_leftover", 999, 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
